// File: rtl/arm_exec_datapath.sv
// Execute datapath for the multi-cycle ARM core: PC, IR, register file, operand latches,
// barrel shifter, ALU, result latch and CPSR flags, plus IR decode feeding the control FSM.
module arm_exec_datapath #(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [31:0] inst_data,
    input  logic        W_PC_EN,
    input  logic        W_IR_EN,
    input  logic        LA,
    input  logic        LB,
    input  logic        LC,
    input  logic        LF,
    input  logic        W_Reg,
    input  logic        S_ctrl,
    input  logic        rm_imm_s_ctrl,
    input  logic [1:0]  rs_imm_s_ctrl,
    input  logic [2:0]  shift_OP_ctrl,
    input  logic [3:0]  ALU_OP_ctrl,
    input  logic        Write_CPSR,
    output logic [31:0] pc,
    output logic        rm_imm_s,
    output logic [1:0]  rs_imm_s,
    output logic [2:0]  Shift_OP,
    output logic [3:0]  ALU_OP,
    output logic        S,
    output logic        TTCC,
    output logic        isCondSatisfy,
    output logic [3:0]  nzcv
);

    logic [31:0] r_pc, r_ir, r_a, r_b, r_c, r_f;
    logic [3:0]  r_nzcv;
    logic [31:0] r_regs [0:14];

    logic [3:0]  w_rn, w_rd, w_rs, w_rm;
    logic [31:0] w_rn_val, w_rm_val, w_rs_val;
    logic [31:0] w_src, w_sh_out, w_ror;
    logic [7:0]  w_amt;
    logic [4:0]  w_rot;
    logic [32:0] w_lsl, w_lsr, w_asr, w_sum;
    logic        w_sh_c, w_arith, w_cin, w_flag_upd;
    logic [31:0] w_x, w_y, w_res;
    logic [3:0]  w_flags;
    logic        w_unused;

    assign w_rn = r_ir[19:16];
    assign w_rd = r_ir[15:12];
    assign w_rs = r_ir[11:8];
    assign w_rm = r_ir[3:0];

    // Index 15 is not stored in the file; it aliases the live PC.
    assign w_rn_val = (w_rn == 4'd15) ? r_pc : r_regs[w_rn];
    assign w_rm_val = (w_rm == 4'd15) ? r_pc : r_regs[w_rm];
    assign w_rs_val = (w_rs == 4'd15) ? r_pc : r_regs[w_rs];

    assign w_src = rm_imm_s_ctrl ? {24'b0, r_ir[7:0]} : r_b;

    always_comb begin
        case (rs_imm_s_ctrl)
            2'b00:   w_amt = {3'b0, r_ir[11:7]};
            2'b01:   w_amt = r_c[7:0];
            2'b10:   w_amt = {3'b0, r_ir[11:8], 1'b0};
            default: w_amt = 8'd0;
        endcase
    end

    // One guard bit beside the data catches the last bit shifted out, including amount 32.
    assign w_lsl = {1'b0, w_src} << w_amt;
    assign w_lsr = {w_src, 1'b0} >> w_amt;
    assign w_asr = $signed({w_src, 1'b0}) >>> w_amt;
    assign w_rot = w_amt[4:0];
    assign w_ror = (w_src >> w_rot) | (w_src << (6'd32 - {1'b0, w_rot}));

    always_comb begin
        w_sh_out = w_src;
        w_sh_c   = r_nzcv[1];
        if (!shift_OP_ctrl[2] && (w_amt != 8'd0)) begin
            case (shift_OP_ctrl[1:0])
                2'b00: begin w_sh_out = w_lsl[31:0]; w_sh_c = w_lsl[32]; end
                2'b01: begin w_sh_out = w_lsr[32:1]; w_sh_c = w_lsr[0];  end
                2'b10: begin w_sh_out = w_asr[32:1]; w_sh_c = w_asr[0];  end
                default: begin w_sh_out = w_ror;     w_sh_c = w_ror[31]; end
            endcase
        end
    end

    // Subtractions become x + ~y + cin so C is NOT borrow and V comes from the adder operands.
    always_comb begin
        w_x     = r_a;
        w_y     = w_sh_out;
        w_cin   = 1'b0;
        w_arith = 1'b1;
        case (ALU_OP_ctrl)
            4'h2, 4'hA: begin w_y = ~w_sh_out; w_cin = 1'b1; end
            4'h3:       begin w_x = w_sh_out; w_y = ~r_a; w_cin = 1'b1; end
            4'h4, 4'hB: w_cin = 1'b0;
            4'h5:       w_cin = r_nzcv[1];
            4'h6:       begin w_y = ~w_sh_out; w_cin = r_nzcv[1]; end
            4'h7:       begin w_x = w_sh_out; w_y = ~r_a; w_cin = r_nzcv[1]; end
            default:    w_arith = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'b0, w_cin};

    always_comb begin
        case (ALU_OP_ctrl)
            4'h0, 4'h8: w_res = r_a & w_sh_out;
            4'h1, 4'h9: w_res = r_a ^ w_sh_out;
            4'hC:       w_res = r_a | w_sh_out;
            4'hD:       w_res = w_sh_out;
            4'hE:       w_res = r_a & ~w_sh_out;
            4'hF:       w_res = ~w_sh_out;
            default:    w_res = w_sum[31:0];
        endcase
    end

    assign w_flags[3] = w_res[31];
    assign w_flags[2] = (w_res == 32'd0);
    assign w_flags[1] = w_arith ? w_sum[32] : w_sh_c;
    assign w_flags[0] = w_arith ? ((w_x[31] == w_y[31]) && (w_res[31] != w_x[31])) : r_nzcv[0];
    assign w_flag_upd = S_ctrl || (ALU_OP_ctrl[3:2] == 2'b10);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_pc   <= PC_RESET;
            r_ir   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_f    <= '0;
            r_nzcv <= '0;
            for (int i = 0; i < 15; i++) r_regs[i] <= '0;
        end else begin
            if (W_IR_EN) r_ir <= inst_data;
            if (W_Reg && (w_rd == 4'd15)) r_pc <= r_f;
            else if (W_PC_EN)             r_pc <= r_pc + PC_STEP;
            if (LA) r_a <= w_rn_val;
            if (LB) r_b <= w_rm_val;
            if (LC) r_c <= w_rs_val;
            if (LF) r_f <= w_res;
            if (Write_CPSR)             r_nzcv <= r_f[31:28];
            else if (LF && w_flag_upd)  r_nzcv <= w_flags;
            if (W_Reg && (w_rd != 4'd15)) r_regs[w_rd] <= r_f;
        end
    end

    always_comb begin
        case (inst_data[31:28])
            4'h0: isCondSatisfy = r_nzcv[2];
            4'h1: isCondSatisfy = !r_nzcv[2];
            4'h2: isCondSatisfy = r_nzcv[1];
            4'h3: isCondSatisfy = !r_nzcv[1];
            4'h4: isCondSatisfy = r_nzcv[3];
            4'h5: isCondSatisfy = !r_nzcv[3];
            4'h6: isCondSatisfy = r_nzcv[0];
            4'h7: isCondSatisfy = !r_nzcv[0];
            4'h8: isCondSatisfy = r_nzcv[1] && !r_nzcv[2];
            4'h9: isCondSatisfy = !r_nzcv[1] || r_nzcv[2];
            4'hA: isCondSatisfy = (r_nzcv[3] == r_nzcv[0]);
            4'hB: isCondSatisfy = (r_nzcv[3] != r_nzcv[0]);
            4'hC: isCondSatisfy = !r_nzcv[2] && (r_nzcv[3] == r_nzcv[0]);
            4'hD: isCondSatisfy = r_nzcv[2] || (r_nzcv[3] != r_nzcv[0]);
            4'hE: isCondSatisfy = 1'b1;
            default: isCondSatisfy = 1'b0;
        endcase
    end

    assign pc       = r_pc;
    assign nzcv     = r_nzcv;
    assign rm_imm_s = r_ir[25];
    assign rs_imm_s = r_ir[25] ? 2'b10 : (r_ir[4] ? 2'b01 : 2'b00);
    assign Shift_OP = r_ir[25] ? 3'b011 : {1'b0, r_ir[6:5]};
    assign ALU_OP   = r_ir[24:21];
    assign S        = r_ir[20];
    assign TTCC     = (r_ir[24:23] == 2'b10);

    assign w_unused = ^{r_ir[31:26], r_c[31:8]};

endmodule

// File: tb/tb_arm_exec_datapath.sv
// Directed bench for arm_exec_datapath: drives the control strobes the way the control FSM would
// and observes register contents by routing them through an ADD into the PC.
module tb_arm_exec_datapath;

    logic        clk;
    logic        Rst;
    logic [31:0] inst_data;
    logic        W_PC_EN, W_IR_EN, LA, LB, LC, LF, W_Reg, S_ctrl;
    logic        rm_imm_s_ctrl;
    logic [1:0]  rs_imm_s_ctrl;
    logic [2:0]  shift_OP_ctrl;
    logic [3:0]  ALU_OP_ctrl;
    logic        Write_CPSR;
    logic [31:0] pc;
    logic        rm_imm_s;
    logic [1:0]  rs_imm_s;
    logic [2:0]  Shift_OP;
    logic [3:0]  ALU_OP;
    logic        S, TTCC, isCondSatisfy;
    logic [3:0]  nzcv;

    int tests = 0;
    int fails = 0;

    logic [3:0] cond_tab [0:6] = '{4'h4, 4'hA, 4'hB, 4'hE, 4'hF, 4'h9, 4'h2};
    logic       cond_exp [0:6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    arm_exec_datapath dut (
        .clk(clk), .Rst(Rst), .inst_data(inst_data),
        .W_PC_EN(W_PC_EN), .W_IR_EN(W_IR_EN), .LA(LA), .LB(LB), .LC(LC), .LF(LF),
        .W_Reg(W_Reg), .S_ctrl(S_ctrl), .rm_imm_s_ctrl(rm_imm_s_ctrl),
        .rs_imm_s_ctrl(rs_imm_s_ctrl), .shift_OP_ctrl(shift_OP_ctrl),
        .ALU_OP_ctrl(ALU_OP_ctrl), .Write_CPSR(Write_CPSR),
        .pc(pc), .rm_imm_s(rm_imm_s), .rs_imm_s(rs_imm_s), .Shift_OP(Shift_OP),
        .ALU_OP(ALU_OP), .S(S), .TTCC(TTCC), .isCondSatisfy(isCondSatisfy), .nzcv(nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        W_PC_EN = 0; W_IR_EN = 0; LA = 0; LB = 0; LC = 0;
        LF = 0; W_Reg = 0; Write_CPSR = 0; S_ctrl = 0;
    endtask

    task automatic set_ctrl(input logic [31:0] inst);
        rm_imm_s_ctrl = inst[25];
        rs_imm_s_ctrl = inst[25] ? 2'b10 : (inst[4] ? 2'b01 : 2'b00);
        shift_OP_ctrl = inst[25] ? 3'b011 : {1'b0, inst[6:5]};
        ALU_OP_ctrl   = inst[24:21];
        S_ctrl        = inst[20];
    endtask

    task automatic load_ir(input logic [31:0] inst);
        inst_data = inst; W_IR_EN = 1; tick();
    endtask

    // Fetch, operand load, execute, writeback (writeback skipped for compare ops).
    task automatic run_inst(input logic [31:0] inst);
        inst_data = inst; W_IR_EN = 1; W_PC_EN = 1; tick();
        LA = 1; LB = 1; LC = 1; tick();
        set_ctrl(inst); LF = 1; tick();
        if (inst[24:23] != 2'b10) begin W_Reg = 1; tick(); end
    endtask

    // ADD PC, Rn, #0x100 exposes R[idx] + 0x100 on the pc output.
    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [31:0] expv);
        run_inst(32'hE280FC01 | ({28'd0, idx} << 16));
        chk(tag, pc, expv + 32'h100);
    endtask

    initial begin
        Rst = 1; inst_data = 0;
        W_PC_EN = 0; W_IR_EN = 0; LA = 0; LB = 0; LC = 0; LF = 0; W_Reg = 0;
        S_ctrl = 0; Write_CPSR = 0;
        rm_imm_s_ctrl = 0; rs_imm_s_ctrl = 0; shift_OP_ctrl = 0; ALU_OP_ctrl = 0;
        repeat (2) @(posedge clk);
        #1 Rst = 0;

        chk("rst_pc", pc, 32'h0);
        chk("rst_nzcv", {28'd0, nzcv}, 32'h0);
        chk("rst_ttcc", {31'd0, TTCC}, 32'h0);
        chk("rst_aluop", {28'd0, ALU_OP}, 32'h0);
        chk("rst_decode", {26'd0, rm_imm_s, rs_imm_s, Shift_OP}, 32'h0);
        chk("rst_cond_eq", {31'd0, isCondSatisfy}, 32'h0);

        // Dirty R1 and flags, then reset asynchronously between clock edges.
        run_inst(32'hE3A01003);
        run_inst(32'hE3510003);
        chk("pre_rst_nzcv", {28'd0, nzcv}, 32'h6);
        load_ir(32'hE3500007);
        chk("pre_rst_ttcc", {31'd0, TTCC}, 32'h1);
        #2 Rst = 1;
        #1;
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_nzcv", {28'd0, nzcv}, 32'h0);
        chk("async_rst_ttcc", {31'd0, TTCC}, 32'h0);
        Rst = 0;
        check_reg("rst_r1", 4'd1, 32'h0);

        // ADDS R2,R0,#5 with R0=7
        run_inst(32'hE3A00007);
        run_inst(32'hE2902005);
        chk("adds_pc", pc, 32'h108);
        chk("adds_nzcv", {28'd0, nzcv}, 32'h0);
        check_reg("adds_r2", 4'd2, 32'd12);

        // CMP R0,#7: flags only, F=0, R0 untouched
        run_inst(32'hE3500007);
        chk("cmp_ttcc", {31'd0, TTCC}, 32'h1);
        chk("cmp_nzcv", {28'd0, nzcv}, 32'h6);
        load_ir(32'hE3A0F000);
        W_Reg = 1; tick();
        chk("cmp_f", pc, 32'h0);
        check_reg("cmp_r0", 4'd0, 32'd7);

        // MOVS R1,#9 keeps C from the flag (shift amount 0); SUBS R3,R1,R1
        run_inst(32'hE3B01009);
        chk("movs_nzcv", {28'd0, nzcv}, 32'h2);
        run_inst(32'hE0513001);
        chk("subs_nzcv", {28'd0, nzcv}, 32'h6);
        check_reg("subs_r3", 4'd3, 32'h0);
        inst_data = 32'h1000_0000; #1;
        chk("cond_ne", {31'd0, isCondSatisfy}, 32'h0);
        inst_data = 32'h0000_0000; #1;
        chk("cond_eq", {31'd0, isCondSatisfy}, 32'h1);

        // R5=0x8000_0001, R6=0x28, R7=32, R8=36
        run_inst(32'hE3A05106);
        run_inst(32'hE3A06028);
        run_inst(32'hE3A07020);
        run_inst(32'hE3A08024);
        run_inst(32'hE1B0F655);
        chk("asr40_out", pc, 32'hFFFF_FFFF);
        chk("asr40_nzcv", {28'd0, nzcv}, 32'hA);
        run_inst(32'hE1B0F715);
        chk("lsl32_out", pc, 32'h0);
        chk("lsl32_nzcv", {28'd0, nzcv}, 32'h6);
        run_inst(32'hE1B0F875);
        chk("ror36_out", pc, 32'h1800_0000);
        chk("ror36_nzcv", {28'd0, nzcv}, 32'h0);
        run_inst(32'hE1B0F0A5);
        chk("lsr1_out", pc, 32'h4000_0000);
        chk("lsr1_nzcv", {28'd0, nzcv}, 32'h2);

        // Signed overflow: 0x7F00_0000 + 0x7F00_0000
        run_inst(32'hE3A0947F);
        run_inst(32'hE099A009);
        chk("adds_ovf_nzcv", {28'd0, nzcv}, 32'h9);

        // W_Reg to PC beats W_PC_EN
        load_ir(32'hE3A0FC01);
        set_ctrl(32'hE3A0FC01); LF = 1; tick();
        W_Reg = 1; W_PC_EN = 1; tick();
        chk("wreg_pc_prio", pc, 32'h100);

        // Write_CPSR beats LF flags; F still loads; W_Reg alongside LF writes old F
        load_ir(32'hE3A0F20A);
        set_ctrl(32'hE3A0F20A); LF = 1; tick();
        Write_CPSR = 1; LF = 1; S_ctrl = 1; ALU_OP_ctrl = 4'hF; tick();
        chk("wcpsr_nzcv", {28'd0, nzcv}, 32'hA);
        ALU_OP_ctrl = 4'hD; LF = 1; W_Reg = 1; tick();
        chk("wreg_old_f", pc, 32'h5FFF_FFFF);
        W_Reg = 1; tick();
        chk("wreg_new_f", pc, 32'hA000_0000);

        for (int i = 0; i < 7; i++) begin
            inst_data = {cond_tab[i], 28'h0};
            #1;
            chk($sformatf("cond_%0h", cond_tab[i]), {31'd0, isCondSatisfy}, {31'd0, cond_exp[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
